bcd_rtc_core: RTL and testbench
===============================

# bcd_rtc_core

Parametrised real-time clock core that keeps hours, minutes and seconds natively in BCD. It is the next generation of the team's 1 Hz BCD clock: the core runs from the system clock through an internal prescaler and adds a run/stop control, a validated time-set handshake, a runtime 12/24-hour display mode, a day-rollover strobe and an optional alarm. It sits between the system clock domain and the seven-segment display driver.

## Interface
- CLK_DIV, default 50_000_000: `clk` cycles per second. Must be ≥ 1; CLK_DIV = 1 gives one second per cycle for simulation.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = time advances; 0 = prescaler and counters hold.
- mode_12h  in  1  display format: 0 = 24 h, 1 = 12 h with AM/PM.
- set_valid  in  1  time-load request.
- set_ready  out  1  core can accept a load.
- set_hh, set_mm, set_ss  in  8 each  load value, packed BCD {tens,ones}, always in 24-hour form.
- set_err  out  1  one-cycle pulse: the last accepted load was invalid and was discarded.
- hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones  out  4 each  displayed digits.
- pm  out  1  1 = PM. Driven only in 12 h mode; 0 in 24 h mode.
- sec_pulse  out  1  one-cycle strobe on each seconds increment.
- day_pulse  out  1  one-cycle strobe on the 23:59:59 → 00:00:00 rollover.
- alarm_hh, alarm_mm  in  8 each  alarm time, packed BCD, 24-hour form (ALARM_EN only).
- alarm_arm  in  1  alarm enable (ALARM_EN only).
- alarm_hit  out  1  one-cycle alarm strobe (ALARM_EN only).

## Operation
- The prescaler counts 0..CLK_DIV-1 while run = 1. Wrapping from CLK_DIV-1 produces an internal tick; there is no tick when CLK_DIV = 1 and run = 0.
- On a tick:
  - ss_ones increments 0–9.
  - ss_tens 0–5, with carry into minutes.
  - Minutes use the same 0–59 scheme.
  - Hours are stored in 24-hour form, 00–23: ones wrap 9→0 with tens increment, and 23 wraps to 00.
- All digit registers are BCD. No binary-to-BCD conversion exists anywhere in the block.
- Load handshake:
  - set_ready = 1 in every cycle except while reset is asserted.
  - A load is accepted on a cycle where set_valid && set_ready.
  - Valid load (each nibble ≤ 9, hh ≤ 23, mm ≤ 59, ss ≤ 59): the time registers take the value and the prescaler clears to 0.
  - Invalid load: state is unchanged, and set_err pulses in the next cycle.
- A tick and an accepted load in the same cycle: the load wins and the tick is discarded.
- 12-hour display mapping, from stored 24-hour hours H:
  - H = 00 → 12, pm = 0.
  - 01–11 → same value, pm = 0.
  - 12 → 12, pm = 1.
  - 13–23 → H−12, pm = 1.
  - The mapping is a registered BCD subtract-12, so mode_12h affects the display only. Stored time is never altered.
- State machine (two states):
  - IDLE: run = 0.
  - COUNT: run = 1.
  - run is sampled every cycle and the transition takes effect in the same cycle.
  - Leaving COUNT freezes the prescaler value; re-entering COUNT resumes from that value.

## Timing
- Reset values: all digits 0, pm = 0, set_err = 0, sec_pulse = 0, day_pulse = 0, alarm_hit = 0, prescaler = 0, set_ready = 0 during reset.
- Digit, pm and strobe outputs are registered. They update one cycle after the tick cycle or the load-accept cycle.
- sec_pulse and day_pulse are aligned with the digit update.
- A mode_12h change reaches the outputs one cycle later.
- Reset asserted mid-operation clears everything on the next edge. Any pending load or tick in that cycle is discarded.

## Configuration
- Macro BCD_RTC_ALARM_EN.
- When defined:
  - A match comparator fires alarm_hit for one cycle when alarm_arm = 1 and the new time equals alarm_hh:alarm_mm:00.
  - The match applies to both a tick and a load that produce that time.
  - An out-of-range alarm value never matches.
- When undefined: the alarm ports are absent and there is no comparator logic.

## Structure
- Package bcd_rtc_pkg holds:
  - typedef bcd_t (4 bit) and bcd2_t (packed {tens,ones}).
  - Constants for maximum hour, minute and second limits.
  - Function bcd2_valid(value, max).
- One sub-module, bcd_digit_pair: a two-digit BCD counter with parameterised tens/ones limits, inc, load, carry_out. It is instantiated three times; hours use the 23 wrap limit.

## Test plan
- CLK_DIV = 4, run = 1, from reset: after 4 cycles, ss = 01 and sec_pulse pulses once; after 240 cycles, mm = 01, ss = 00.
- Load 23:59:58, CLK_DIV = 1: two ticks later digits = 00:00:00 and day_pulse pulses exactly once, aligned with the update.
- Load hh = 0x24, and separately mm = 0x5A: set_err pulses one cycle later and the time is unchanged.
- mode_12h = 1 with stored 00:15:00 → display 12:15 pm = 0; stored 13:05:00 → 01:05 pm = 1; stored 12:00:00 → 12:00 pm = 1.
- run = 0 for 10 cycles mid-second, CLK_DIV = 8: the time holds, and after run returns to 1 the next tick arrives after the remaining prescaler count, not a full period. Also check a load coinciding with a tick: the loaded value is shown and the tick is dropped.
- BCD_RTC_ALARM_EN: alarm 07:30, arm = 1, load 07:29:59 → alarm_hit for one cycle at 07:30:00. With arm = 0 there is no pulse.

Source files
------------

// File: rtl/bcd_rtc_pkg.sv
// bcd_rtc_pkg: shared BCD types, time limits and a range check
// for the bcd_rtc_core real-time clock.
package bcd_rtc_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } bcd2_t;

   localparam bcd2_t HOUR_MAX = 8'h23;
   localparam bcd2_t MIN_MAX  = 8'h59;
   localparam bcd2_t SEC_MAX  = 8'h59;

   // Packed BCD orders like its numeric value once both nibbles are digits.
   function automatic logic bcd2_valid(input bcd2_t value, input bcd2_t max);
      return (value.tens <= 4'd9) && (value.ones <= 4'd9) &&
             ({value.tens, value.ones} <= {max.tens, max.ones});
   endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD counter wrapping to 00 after LIMIT,
// with parallel load and a carry strobe on the wrap.
module bcd_digit_pair
   import bcd_rtc_pkg::*;
#(
   parameter bcd2_t LIMIT = SEC_MAX
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  inc,
   input  logic  load,
   input  bcd2_t din,
   output bcd2_t nxt,
   output logic  carry_out
);

   bcd2_t q;
   logic  at_limit;

   assign at_limit  = (q == LIMIT);
   assign carry_out = inc && !load && at_limit;

   always_comb begin
      nxt = q;
      if (load) begin
         nxt = din;
      end else if (inc) begin
         if (at_limit) begin
            nxt = '0;
         end else if (q.ones == 4'd9) begin
            nxt.tens = q.tens + 4'd1;
            nxt.ones = 4'd0;
         end else begin
            nxt.ones = q.ones + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= nxt;
   end

endmodule

// File: rtl/bcd_rtc_core.sv
// bcd_rtc_core: prescaled BCD real-time clock with set handshake and 12/24 h display.
// Define BCD_RTC_ALARM_EN to build the hh:mm alarm comparator and its ports.
module bcd_rtc_core
   import bcd_rtc_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       mode_12h,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic       set_err,
   output logic [3:0] hh_tens,
   output logic [3:0] hh_ones,
   output logic [3:0] mm_tens,
   output logic [3:0] mm_ones,
   output logic [3:0] ss_tens,
   output logic [3:0] ss_ones,
   output logic       pm,
   output logic       sec_pulse,
`ifdef BCD_RTC_ALARM_EN
   output logic       day_pulse,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_arm,
   output logic       alarm_hit
`else
   output logic       day_pulse
`endif
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] COUNT = 1'b1;

   logic [0:0]    state;
   logic [PW-1:0] presc;
   logic          accept;
   logic          load_ok;
   logic          tick;
   logic          tick_eff;
   logic          ss_carry;
   logic          mm_carry;
   logic          hh_carry;
   bcd2_t         ss_nxt;
   bcd2_t         mm_nxt;
   bcd2_t         hh_nxt;
   logic [7:0]    hv;
   logic [7:0]    disp_h;
   logic          pm_n;

   assign state     = run ? COUNT : IDLE;
   assign set_ready = !reset;
   assign accept    = set_valid && set_ready;
   assign load_ok   = accept &&
                      bcd2_valid(set_hh, HOUR_MAX) &&
                      bcd2_valid(set_mm, MIN_MAX) &&
                      bcd2_valid(set_ss, SEC_MAX);
   assign tick      = (state == COUNT) && (presc == PMAX);
   // Any accepted load, good or bad, swallows a coincident tick.
   assign tick_eff  = tick && !accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
      end else if (load_ok) begin
         presc <= '0;
      end else begin
         unique case (state)
            COUNT: if (!accept) presc <= tick ? '0 : presc + PW'(1);
            IDLE:  ;
         endcase
      end
   end

   bcd_digit_pair #(.LIMIT(SEC_MAX)) u_ss (
      .clk       (clk),
      .reset     (reset),
      .inc       (tick_eff),
      .load      (load_ok),
      .din       (bcd2_t'(set_ss)),
      .nxt       (ss_nxt),
      .carry_out (ss_carry)
   );

   bcd_digit_pair #(.LIMIT(MIN_MAX)) u_mm (
      .clk       (clk),
      .reset     (reset),
      .inc       (ss_carry),
      .load      (load_ok),
      .din       (bcd2_t'(set_mm)),
      .nxt       (mm_nxt),
      .carry_out (mm_carry)
   );

   bcd_digit_pair #(.LIMIT(HOUR_MAX)) u_hh (
      .clk       (clk),
      .reset     (reset),
      .inc       (mm_carry),
      .load      (load_ok),
      .din       (bcd2_t'(set_hh)),
      .nxt       (hh_nxt),
      .carry_out (hh_carry)
   );

   // BCD subtract-12 on the upcoming hour, so the display tracks the update.
   always_comb begin
      hv     = hh_nxt;
      disp_h = hv;
      pm_n   = 1'b0;
      if (mode_12h) begin
         pm_n = (hv >= 8'h12);
         if (hv == 8'h00) begin
            disp_h = 8'h12;
         end else if (hv > 8'h12) begin
            if (hv[3:0] >= 4'd2) disp_h = {hv[7:4] - 4'd1, hv[3:0] - 4'd2};
            else                 disp_h = {hv[7:4] - 4'd2, hv[3:0] + 4'd8};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         {hh_tens, hh_ones} <= '0;
         {mm_tens, mm_ones} <= '0;
         {ss_tens, ss_ones} <= '0;
         pm        <= 1'b0;
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         {hh_tens, hh_ones} <= disp_h;
         {mm_tens, mm_ones} <= mm_nxt;
         {ss_tens, ss_ones} <= ss_nxt;
         pm        <= pm_n;
         set_err   <= accept && !load_ok;
         sec_pulse <= tick_eff;
         day_pulse <= hh_carry;
      end
   end

`ifdef BCD_RTC_ALARM_EN
   logic alarm_ok;
   logic alarm_match;

   assign alarm_ok    = bcd2_valid(alarm_hh, HOUR_MAX) &&
                        bcd2_valid(alarm_mm, MIN_MAX);
   assign alarm_match = alarm_arm && alarm_ok &&
                        (tick_eff || load_ok) &&
                        (hh_nxt == bcd2_t'(alarm_hh)) &&
                        (mm_nxt == bcd2_t'(alarm_mm)) &&
                        (ss_nxt == '0);

   always_ff @(posedge clk) begin
      if (reset) alarm_hit <= 1'b0;
      else       alarm_hit <= alarm_match;
   end
`endif

endmodule

// File: tb/tb_bcd_rtc_core.sv
// tb_bcd_rtc_core: scoreboard bench for bcd_rtc_core against a
// seconds-of-day reference model, directed cases then random traffic.
module tb_bcd_rtc_core;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic       mode_12h;
   logic       set_valid;
   logic       set_ready;
   logic [7:0] set_hh;
   logic [7:0] set_mm;
   logic [7:0] set_ss;
   logic       set_err;
   logic [3:0] hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones;
   logic       pm;
   logic       sec_pulse;
   logic       day_pulse;
   logic       hit_act;
`ifdef BCD_RTC_ALARM_EN
   logic [7:0] alarm_hh;
   logic [7:0] alarm_mm;
   logic       alarm_arm;
   logic       alarm_hit;
   assign hit_act = alarm_hit;
`else
   assign hit_act = 1'b0;
`endif

   typedef struct packed {
      logic [23:0] dig;
      logic        pm;
      logic        err;
      logic        sec;
      logic        day;
      logic        rdy;
      logic        hit;
   } obs_t;

   obs_t expq[$];
   int   total = 0;
   int   bad   = 0;
   int   tod   = 0;
   int   pre   = 0;
   int   ncyc  = 0;

   bcd_rtc_core #(.CLK_DIV(DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .mode_12h  (mode_12h),
      .set_valid (set_valid),
      .set_ready (set_ready),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .set_ss    (set_ss),
      .set_err   (set_err),
      .hh_tens   (hh_tens),
      .hh_ones   (hh_ones),
      .mm_tens   (mm_tens),
      .mm_ones   (mm_ones),
      .ss_tens   (ss_tens),
      .ss_ones   (ss_ones),
      .pm        (pm),
      .sec_pulse (sec_pulse),
`ifdef BCD_RTC_ALARM_EN
      .day_pulse (day_pulse),
      .alarm_hh  (alarm_hh),
      .alarm_mm  (alarm_mm),
      .alarm_arm (alarm_arm),
      .alarm_hit (alarm_hit)
`else
      .day_pulse (day_pulse)
`endif
   );

   always #5 clk = ~clk;

   function automatic int bcd_val(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit bcd_ok(input logic [7:0] b, input int max);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd_val(b) <= max);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   // Reference model: advance one clock, push the outputs expected after the edge.
   task automatic cycle();
      obs_t e;
      int   h;
      bit   tk;
      bit   ld;
      e  = '0;
      tk = 0;
      ld = 0;
      if (reset) begin
         tod = 0;
         pre = 0;
      end else begin
         e.rdy = 1'b1;
         if (set_valid) begin
            if (bcd_ok(set_hh, 23) && bcd_ok(set_mm, 59) && bcd_ok(set_ss, 59)) begin
               tod = bcd_val(set_hh) * 3600 + bcd_val(set_mm) * 60 + bcd_val(set_ss);
               pre = 0;
               ld  = 1;
            end else begin
               e.err = 1'b1;
            end
         end else if (run) begin
            if (pre == DIV - 1) begin
               pre   = 0;
               tk    = 1;
               e.sec = 1'b1;
               e.day = (tod == 86399);
               tod   = (tod + 1) % 86400;
            end else begin
               pre++;
            end
         end
         h = tod / 3600;
         if (mode_12h) begin
            e.pm = (h >= 12);
            h    = (h % 12 == 0) ? 12 : h % 12;
         end
         e.dig = {to_bcd(h), to_bcd((tod / 60) % 60), to_bcd(tod % 60)};
`ifdef BCD_RTC_ALARM_EN
         e.hit = alarm_arm && (tk || ld) &&
                 bcd_ok(alarm_hh, 23) && bcd_ok(alarm_mm, 59) &&
                 (tod == bcd_val(alarm_hh) * 3600 + bcd_val(alarm_mm) * 60);
`endif
      end
      expq.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      set_valid = 1'b1;
      set_hh    = h;
      set_mm    = m;
      set_ss    = s;
      cycle();
      set_valid = 1'b0;
   endtask

   task automatic rand_set();
      int t;
      if ($urandom % 4 == 0) begin
         set_hh = 8'($urandom);
         set_mm = 8'($urandom);
         set_ss = 8'($urandom);
      end else begin
         t = $urandom % 86400;
         if ($urandom % 2 == 1) t = t - t % 60 + 58 + int'($urandom % 2);
         if ($urandom % 4 == 0) t = 86398 + int'($urandom % 2);
         set_hh = to_bcd(t / 3600);
         set_mm = to_bcd((t / 60) % 60);
         set_ss = to_bcd(t % 60);
`ifdef BCD_RTC_ALARM_EN
         if ($urandom % 2 == 1) begin
            alarm_hh = to_bcd(((t + 1) % 86400) / 3600);
            alarm_mm = to_bcd((((t + 1) % 86400) / 60) % 60);
         end else if ($urandom % 3 == 0) begin
            alarm_hh = 8'($urandom);
            alarm_mm = 8'($urandom);
         end
`endif
      end
   endtask

   // Monitor: one observation per clock, taken just after the edge.
   initial begin
      obs_t e;
      obs_t a;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones,
                 pm, set_err, sec_pulse, day_pulse, set_ready, hit_act};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs cyc=%0d got dig=%h pm=%b err=%b sec=%b day=%b rdy=%b hit=%b want dig=%h pm=%b err=%b sec=%b day=%b rdy=%b hit=%b",
                        ncyc, a.dig, a.pm, a.err, a.sec, a.day, a.rdy, a.hit,
                        e.dig, e.pm, e.err, e.sec, e.day, e.rdy, e.hit);
            end
            ncyc++;
         end
      end
   end

   initial begin
      reset     = 1'b1;
      run       = 1'b0;
      mode_12h  = 1'b0;
      set_valid = 1'b0;
      set_hh    = '0;
      set_mm    = '0;
      set_ss    = '0;
`ifdef BCD_RTC_ALARM_EN
      alarm_hh  = 8'h07;
      alarm_mm  = 8'h30;
      alarm_arm = 1'b0;
`endif
      repeat (3) cycle();
      reset = 1'b0;
      run   = 1'b1;
      repeat (DIV * 60 + 4) cycle();

      load(8'h23, 8'h59, 8'h58);
      repeat (3 * DIV + 2) cycle();

      load(8'h24, 8'h00, 8'h00);
      cycle();
      load(8'h10, 8'h5A, 8'h00);
      cycle();

      mode_12h = 1'b1;
      load(8'h00, 8'h15, 8'h00);
      cycle();
      load(8'h13, 8'h05, 8'h00);
      cycle();
      load(8'h12, 8'h00, 8'h00);
      cycle();
      load(8'h23, 8'h00, 8'h00);
      mode_12h = 1'b0;
      repeat (2) cycle();

      load(8'h08, 8'h00, 8'h00);
      repeat (2) cycle();
      run = 1'b0;
      repeat (10) cycle();
      run = 1'b1;
      repeat (2 * DIV) cycle();

      load(8'h10, 8'h00, 8'h00);
      repeat (DIV - 1) cycle();
      load(8'h11, 8'h22, 8'h33);
      repeat (DIV + 1) cycle();

`ifdef BCD_RTC_ALARM_EN
      alarm_hh  = 8'h07;
      alarm_mm  = 8'h30;
      alarm_arm = 1'b1;
      load(8'h07, 8'h29, 8'h59);
      repeat (DIV + 2) cycle();
      alarm_arm = 1'b0;
      load(8'h07, 8'h29, 8'h59);
      repeat (DIV + 2) cycle();
`endif

      reset = 1'b1;
      cycle();
      reset = 1'b0;

      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom % 300 == 0);
         run       = ($urandom % 10 != 0);
         if ($urandom % 40 == 0) mode_12h = ~mode_12h;
         set_valid = ($urandom % 25 == 0);
`ifdef BCD_RTC_ALARM_EN
         if ($urandom % 50 == 0) alarm_arm = ~alarm_arm;
`endif
         if (set_valid) rand_set();
         cycle();
      end

      reset     = 1'b0;
      set_valid = 1'b0;
      @(posedge clk);
      #3;
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending want=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
